accumulator_serial_receiver: RTL and testbench

- Receive end of the accumulator serial readout link (serialStart / serialOut); rebuilds the parallel accumulator words and hands them to a downstream capture block.
- Sits on the test/FPGA side, or in a loopback self-test path, clocked by the same serial clock that shifts the frame out.
- Detects frame boundaries, counts words, flags framing errors and output overruns.

---
 rtl/accumulator_serial_receiver.sv | 105 ++++++++++
 tb/tb_accumulator_serial_receiver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_serial_receiver.sv
// Receive side of the accumulator serial readout link: rebuilds MSB-first words
// from serialStart/serialIn and hands them to a capture block over valid/ready.
module accumulator_serial_receiver #(
  parameter int ACC_WIDTH = 16,
  parameter int NUM_WORDS = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serialStart,
  input  logic                 serialIn,
  output logic [ACC_WIDTH-1:0] word_data,
  output logic [IDX_WIDTH-1:0] word_index,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 frame_done,
  output logic                 frame_error,
  output logic                 overrun,
  output logic [15:0]          frame_count
);

  localparam int BW = $clog2(ACC_WIDTH);
  localparam logic [BW-1:0]        BIT_LAST  = BW'(ACC_WIDTH - 1);
  localparam logic [IDX_WIDTH-1:0] WORD_LAST = IDX_WIDTH'(NUM_WORDS - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-2:0]   shift_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [IDX_WIDTH-1:0]   word_cnt_q;

  logic shift_en, restart, word_done, last_word;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: a start marker always (re)enters SHIFT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (serialStart) state_d = S_SHIFT;
      S_SHIFT: if (last_word)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded control; a start marker inside SHIFT overrides any word completion
  always_comb begin
    shift_en  = serialStart || (state_q == S_SHIFT);
    restart   = serialStart && (state_q == S_SHIFT);
    word_done = (state_q == S_SHIFT) && !serialStart && (bit_cnt_q == BIT_LAST);
    last_word = word_done && (word_cnt_q == WORD_LAST);
  end

  // Handshake: word_valid holds word_data/word_index stable until a cycle with
  // word_ready=1 (transfer on that edge); a word completing while the register
  // is full and not being accepted is dropped and flagged as overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      word_data   <= '0;
      word_index  <= '0;
      word_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      if (word_valid && word_ready) word_valid <= 1'b0;
      if (shift_en) shift_q <= {shift_q[ACC_WIDTH-3:0], serialIn};

      if (serialStart) begin
        bit_cnt_q  <= BW'(1);
        word_cnt_q <= '0;
        if (restart) frame_error <= 1'b1;
      end else if (state_q == S_SHIFT) begin
        if (word_done) begin
          bit_cnt_q  <= '0;
          word_cnt_q <= last_word ? '0 : word_cnt_q + IDX_WIDTH'(1);
          if (!word_valid || word_ready) begin
            word_data  <= {shift_q, serialIn};
            word_index <= word_cnt_q;
            word_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          if (last_word) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_accumulator_serial_receiver.sv
// Directed bench for accumulator_serial_receiver: bit-level frame model,
// per-cycle output compare, and a word scoreboard fed from the directed vectors.
module tb_accumulator_serial_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        serialStart = 1'b0;
  logic        serialIn = 1'b0;
  logic        word_ready = 1'b1;
  logic [15:0] word_data;
  logic [1:0]  word_index;
  logic        word_valid, frame_done, frame_error, overrun;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  accumulator_serial_receiver #(.ACC_WIDTH(16), .NUM_WORDS(4), .IDX_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .serialStart(serialStart), .serialIn(serialIn),
    .word_data(word_data), .word_index(word_index), .word_valid(word_valid),
    .word_ready(word_ready), .frame_done(frame_done), .frame_error(frame_error),
    .overrun(overrun), .frame_count(frame_count)
  );

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  bit checking = 1'b0;
  logic [17:0] exp_q[$];

  // Frame-level model: words are the running value of the bits since the frame
  // start, delivered the cycle after their sixteenth bit.
  logic [15:0] m_data, m_count, acc;
  logic [1:0]  m_idx;
  logic        m_valid, m_done, m_err, m_ovr;
  bit          in_frame;
  int          nb, wc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_data = 0; m_idx = 0; m_valid = 0; m_done = 0; m_err = 0; m_ovr = 0;
      m_count = 0; acc = 0; in_frame = 0; nb = 0; wc = 0;
    end else begin
      m_done = 0;
      if (m_valid && word_ready) m_valid = 0;
      if (serialStart) begin
        if (in_frame) m_err = 1;
        in_frame = 1; acc = {15'd0, serialIn}; nb = 1; wc = 0;
      end else if (in_frame) begin
        acc = {acc[14:0], serialIn};
        nb++;
        if (nb == 16) begin
          nb = 0;
          if (!m_valid) begin
            m_data = acc; m_idx = wc[1:0]; m_valid = 1;
          end else begin
            m_ovr = 1;
          end
          if (wc == 3) begin
            m_done = 1; m_count = m_count + 16'd1; in_frame = 0; wc = 0;
          end else begin
            wc++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("word_valid", {31'd0, word_valid}, {31'd0, m_valid});
      chk("frame_done", {31'd0, frame_done}, {31'd0, m_done});
      chk("frame_error", {31'd0, frame_error}, {31'd0, m_err});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      chk("frame_count", {16'd0, frame_count}, {16'd0, m_count});
      if (m_valid) begin
        chk("word_data", {16'd0, word_data}, {16'd0, m_data});
        chk("word_index", {30'd0, word_index}, {30'd0, m_idx});
      end
      if (frame_done) done_seen++;
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected: got idx %0d data %0h expected no word", word_index, word_data);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("sb_word", {14'd0, word_index, word_data}, {14'd0, e});
        end
      end
    end
  end

  task automatic send_bit(input logic s, input logic b);
    serialStart = s; serialIn = b;
    @(posedge clk); #1;
    serialStart = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic first, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(first && (i == 0), w[15-i]);
  endtask

  task automatic send_frame(input logic [15:0] a, b, c, d);
    exp_q.push_back({2'd0, a}); exp_q.push_back({2'd1, b});
    exp_q.push_back({2'd2, c}); exp_q.push_back({2'd3, d});
    send_word(a, 1'b1, 16); send_word(b, 1'b0, 16);
    send_word(c, 1'b0, 16); send_word(d, 1'b0, 16);
  endtask

  task automatic idle(input int n);
    serialStart = 1'b0; serialIn = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset with a coincident start marker, which must be ignored
  task automatic do_reset();
    reset = 1'b1; serialStart = 1'b1; serialIn = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; serialStart = 1'b0; serialIn = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (word_valid && n < 20) begin idle(1); n++; end
    chk("drain_timeout", {31'd0, word_valid}, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checking = 1'b1;
    chk("rst_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_data", {16'd0, word_data}, 32'd0);
    chk("rst_count", {16'd0, frame_count}, 32'd0);

    // Single frame
    done_seen = 0;
    send_frame(16'h1234, 16'hABCD, 16'h0001, 16'h8000);
    idle(3); drain();
    chk("t1_count", {16'd0, frame_count}, 32'd1);
    chk("t1_done", done_seen, 32'd1);
    chk("t1_flags", {30'd0, frame_error, overrun}, 32'd0);

    // Back-to-back frames
    do_reset(); idle(1); done_seen = 0;
    send_frame(16'h0F0F, 16'hF0F0, 16'h1357, 16'h2468);
    send_frame(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'h7FFF);
    idle(3); drain();
    chk("t2_count", {16'd0, frame_count}, 32'd2);
    chk("t2_done", done_seen, 32'd2);
    chk("t2_err", {31'd0, frame_error}, 32'd0);

    // Consumer stalled for a whole frame
    do_reset(); idle(1);
    word_ready = 1'b0;
    exp_q.push_back({2'd0, 16'h1234});
    send_word(16'h1234, 1'b1, 16);
    chk("t3_ovr_early", {31'd0, overrun}, 32'd0);
    send_word(16'hABCD, 1'b0, 16);
    chk("t3_ovr_set", {31'd0, overrun}, 32'd1);
    send_word(16'h0001, 1'b0, 16);
    send_word(16'h8000, 1'b0, 16);
    idle(2);
    chk("t3_data", {16'd0, word_data}, 32'h1234);
    chk("t3_index", {30'd0, word_index}, 32'd0);
    chk("t3_valid", {31'd0, word_valid}, 32'd1);
    chk("t3_count", {16'd0, frame_count}, 32'd1);
    word_ready = 1'b1;
    idle(2); drain();
    chk("t3_ovr_sticky", {31'd0, overrun}, 32'd1);

    // Start marker at bit 7 of word 2, then a clean frame from that cycle
    do_reset(); idle(1); done_seen = 0;
    exp_q.push_back({2'd0, 16'h1111}); exp_q.push_back({2'd1, 16'h2222});
    send_word(16'h1111, 1'b1, 16);
    send_word(16'h2222, 1'b0, 16);
    send_word(16'h3333, 1'b0, 7);
    send_frame(16'h5555, 16'hAAAA, 16'hFFFF, 16'h0000);
    idle(3); drain();
    chk("t4_err", {31'd0, frame_error}, 32'd1);
    chk("t4_count", {16'd0, frame_count}, 32'd1);
    chk("t4_done", done_seen, 32'd1);

    // Reset at bit 9 of word 1
    do_reset(); idle(1);
    exp_q.push_back({2'd0, 16'h4321});
    send_word(16'h4321, 1'b1, 16);
    send_word(16'h9999, 1'b0, 9);
    do_reset();
    chk("t5_rst_all", {word_data, word_index, word_valid, frame_done, frame_error, overrun, 10'd0},
        32'd0);
    chk("t5_rst_count", {16'd0, frame_count}, 32'd0);
    idle(2);
    send_frame(16'h0102, 16'h0304, 16'h0506, 16'h0708);
    idle(3); drain();
    chk("t5_count", {16'd0, frame_count}, 32'd1);
    chk("t5_err", {31'd0, frame_error}, 32'd0);

    // frame_count wrap from 0xFFFF
    do_reset(); idle(1); done_seen = 0;
    force dut.frame_count = 16'hFFFF;
    m_count = 16'hFFFF;
    #1 release dut.frame_count;
    send_frame(16'hFACE, 16'h0BAD, 16'hC0DE, 16'h0042);
    idle(3); drain();
    chk("t6_wrap", {16'd0, frame_count}, 32'd0);
    chk("t6_done", done_seen, 32'd1);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
